// File: rtl/pipelined_control_unit_if.sv
// ID-stage control interface: IF/ID instruction and EX hazard inputs in, registered
// ID/EX control bundle and stall/sequencer status out.
interface pipelined_control_unit_if;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;

    logic        stall;
    logic        ctrl_valid;
    logic        reg_write;
    logic        mem_to_reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        branch_eq;
    logic        jump;
    logic        link;
    logic        jr;
    logic        alu_source;
    logic        alu_source_shift;
    logic        reg_dst;
    logic [3:0]  alu_control;
    logic [25:0] target;
    logic        muldiv_start;
    logic [1:0]  muldiv_op;
    logic [1:0]  hilo_read;
    logic        muldiv_busy;
    logic        illegal;

    modport master (
        output instruction, instr_valid, flush, ex_mem_read, ex_rt,
        input  stall, ctrl_valid, reg_write, mem_to_reg_write, mem_read, mem_write, branch,
               branch_eq, jump, link, jr, alu_source, alu_source_shift, reg_dst, alu_control,
               target, muldiv_start, muldiv_op, hilo_read, muldiv_busy, illegal
    );

    modport slave (
        input  instruction, instr_valid, flush, ex_mem_read, ex_rt,
        output stall, ctrl_valid, reg_write, mem_to_reg_write, mem_read, mem_write, branch,
               branch_eq, jump, link, jr, alu_source, alu_source_shift, reg_dst, alu_control,
               target, muldiv_start, muldiv_op, hilo_read, muldiv_busy, illegal
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// Registered MIPS ID-stage control unit: decode into the ID/EX bundle, load-use interlock,
// flush bubbling, illegal-op flagging and a HI/LO multiply/divide occupancy sequencer.
module pipelined_control_unit #(
    parameter bit          ENABLE_MULDIV = 1'b1,
    parameter int unsigned MUL_LATENCY   = 4,
    parameter int unsigned DIV_LATENCY   = 32,
    parameter int unsigned CNT_W         = 6
) (
    input logic                      clk,
    input logic                      reset,
    pipelined_control_unit_if.slave  bus
);

    localparam logic [CNT_W-1:0] MulCntInit = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] DivCntInit = CNT_W'(DIV_LATENCY - 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    typedef struct packed {
        logic        ctrl_valid;
        logic        reg_write;
        logic        mem_to_reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        branch_eq;
        logic        jump;
        logic        link;
        logic        jr;
        logic        alu_source;
        logic        alu_source_shift;
        logic        reg_dst;
        logic [3:0]  alu_control;
        logic [25:0] target;
        logic        muldiv_start;
        logic [1:0]  muldiv_op;
        logic [1:0]  hilo_read;
        logic        illegal;
    } ctrl_t;

    ctrl_t            dec;
    ctrl_t            ctrl_d, ctrl_q;
    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt;
    logic       known, is_md, is_hilo, reads_rt;
    logic       load_use, busy_stall, stall, accept;

    assign opcode = bus.instruction[31:26];
    assign rs     = bus.instruction[25:21];
    assign rt     = bus.instruction[20:16];
    assign funct  = bus.instruction[5:0];

    always_comb begin
        dec     = '0;
        known   = 1'b1;
        is_md   = 1'b0;
        is_hilo = 1'b0;
        case (opcode)
            6'h00: begin
                dec.reg_write = 1'b1;
                dec.reg_dst   = 1'b1;
                case (funct)
                    6'h20, 6'h21: dec.alu_control = 4'b0001;
                    6'h22, 6'h23: dec.alu_control = 4'b0010;
                    6'h24:        dec.alu_control = 4'b0011;
                    6'h25:        dec.alu_control = 4'b0100;
                    6'h26:        dec.alu_control = 4'b0101;
                    6'h27:        dec.alu_control = 4'b0110;
                    6'h2a:        dec.alu_control = 4'b0111;
                    6'h00, 6'h02, 6'h03: begin
                        dec.alu_source_shift = 1'b1;
                        dec.alu_control      = (funct == 6'h00) ? 4'b1000 :
                                               (funct == 6'h02) ? 4'b1001 : 4'b1010;
                    end
                    6'h08: begin
                        dec.reg_write = 1'b0;
                        dec.reg_dst   = 1'b0;
                        dec.jump      = 1'b1;
                        dec.jr        = 1'b1;
                    end
                    6'h18, 6'h19, 6'h1a, 6'h1b: begin
                        dec.reg_write    = 1'b0;
                        dec.reg_dst      = 1'b0;
                        dec.muldiv_start = 1'b1;
                        dec.muldiv_op    = funct[1:0];
                        is_md            = ENABLE_MULDIV;
                        known            = ENABLE_MULDIV;
                    end
                    6'h10, 6'h12: begin
                        dec.hilo_read = (funct == 6'h10) ? 2'b10 : 2'b01;
                        is_hilo       = ENABLE_MULDIV;
                        known         = ENABLE_MULDIV;
                    end
                    default: known = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin
                dec.reg_write   = 1'b1;
                dec.alu_source  = 1'b1;
                dec.alu_control = 4'b0001;
            end
            6'h0c, 6'h0d, 6'h0e: begin
                dec.reg_write   = 1'b1;
                dec.alu_source  = 1'b1;
                dec.alu_control = (opcode == 6'h0c) ? 4'b0011 :
                                  (opcode == 6'h0d) ? 4'b0100 : 4'b0101;
            end
            6'h23: begin
                dec.reg_write        = 1'b1;
                dec.mem_to_reg_write = 1'b1;
                dec.mem_read         = 1'b1;
                dec.alu_source       = 1'b1;
                dec.alu_control      = 4'b0001;
            end
            6'h2b: begin
                dec.mem_write   = 1'b1;
                dec.alu_source  = 1'b1;
                dec.alu_control = 4'b0001;
            end
            6'h04, 6'h05: begin
                dec.branch      = 1'b1;
                dec.branch_eq   = (opcode == 6'h04);
                dec.alu_control = 4'b0010;
            end
            6'h02, 6'h03: begin
                dec.jump      = 1'b1;
                dec.link      = (opcode == 6'h03);
                dec.reg_write = (opcode == 6'h03);
                dec.target    = bus.instruction[25:0];
            end
            default: known = 1'b0;
        endcase
        // An unknown encoding must not leak partial decode into the bundle.
        if (!known) dec = '0;
        dec.ctrl_valid = known;
    end

    always_comb begin
        reads_rt   = (opcode == 6'h00) || (opcode == 6'h04) || (opcode == 6'h05) ||
                     (opcode == 6'h2b);
        load_use   = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                     ((bus.ex_rt == rs) || ((bus.ex_rt == rt) && reads_rt));
        busy_stall = (state_q == StBusy) && (is_md || is_hilo);
        stall      = bus.instr_valid && (load_use || busy_stall);
        accept     = bus.instr_valid && !bus.flush && !stall;

        ctrl_d = '0;
        if (accept) begin
            if (known) ctrl_d = dec;
            else       ctrl_d.illegal = 1'b1;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept && is_md) begin
                    state_d = StBusy;
                    cnt_d   = funct[1] ? DivCntInit : MulCntInit;
                end
            end
            StBusy: begin
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stall            = stall;
    assign bus.ctrl_valid       = ctrl_q.ctrl_valid;
    assign bus.reg_write        = ctrl_q.reg_write;
    assign bus.mem_to_reg_write = ctrl_q.mem_to_reg_write;
    assign bus.mem_read         = ctrl_q.mem_read;
    assign bus.mem_write        = ctrl_q.mem_write;
    assign bus.branch           = ctrl_q.branch;
    assign bus.branch_eq        = ctrl_q.branch_eq;
    assign bus.jump             = ctrl_q.jump;
    assign bus.link             = ctrl_q.link;
    assign bus.jr               = ctrl_q.jr;
    assign bus.alu_source       = ctrl_q.alu_source;
    assign bus.alu_source_shift = ctrl_q.alu_source_shift;
    assign bus.reg_dst          = ctrl_q.reg_dst;
    assign bus.alu_control      = ctrl_q.alu_control;
    assign bus.target           = ctrl_q.target;
    assign bus.muldiv_start     = ctrl_q.muldiv_start;
    assign bus.muldiv_op        = ctrl_q.muldiv_op;
    assign bus.hilo_read        = ctrl_q.hilo_read;
    assign bus.illegal          = ctrl_q.illegal;
    assign bus.muldiv_busy      = (state_q == StBusy);

endmodule
